clangpu_imem_axi_slave: RTL

//  Synthesizable AXI4 read-only slave serving the ClangPU instruction memory. It

---
 rtl/clangpu_imem_axi_slave_if.sv | 31 +++
 rtl/clangpu_imem_axi_slave.sv | 110 +++++++++++
 2 files changed

// File: rtl/clangpu_imem_axi_slave_if.sv
// AXI4 read-address/read-data channel bundle between the fetch master and the imem slave.
// The slave modport drives ARREADY and the R channel; the master drives AR and RREADY.
interface clangpu_imem_axi_slave_if #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_ID_WIDTH       = 1
);
  logic [C_ID_WIDTH-1:0]       ARID;
  logic [C_AXI_ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]                  ARLEN;
  logic [2:0]                  ARSIZE;
  logic [1:0]                  ARBURST;
  logic                        ARVALID;
  logic                        ARREADY;
  logic [C_ID_WIDTH-1:0]       RID;
  logic [C_AXI_DATA_WIDTH-1:0] RDATA;
  logic [1:0]                  RRESP;
  logic                        RLAST;
  logic                        RVALID;
  logic                        RREADY;

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/clangpu_imem_axi_slave.sv
// Read-only AXI4 slave over a preloadable word RAM serving the ClangPU fetch path.
// First RVALID 2 cycles after AR handshake, then 1 beat/cycle; R outputs hold while RREADY is low.
module clangpu_imem_axi_slave #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_ID_WIDTH       = 1,
  parameter int MEM_DEPTH        = 4096
) (
  input  logic                          AXI_CLK,
  input  logic                          AXI_RST,
  clangpu_imem_axi_slave_if.slave       axi,
  input  logic                          LOAD_EN,
  input  logic [$clog2(MEM_DEPTH)-1:0]  LOAD_ADDR,
  input  logic [C_AXI_DATA_WIDTH-1:0]   LOAD_DATA
);
  localparam int IDXW = $clog2(MEM_DEPTH);
  localparam int WAW  = C_AXI_ADDR_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t                state_q, state_d;
  logic [C_ID_WIDTH-1:0] rid_q, rid_d;
  logic [WAW-1:0]        addr_q, addr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  fixed_q, fixed_d;

  logic [C_AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [C_AXI_DATA_WIDTH-1:0] ram_q;
  logic                        ram_re;
  logic [IDXW-1:0]             ram_idx;
  logic                        beat_err;
  logic                        unused_araddr;

  assign unused_araddr = ^axi.ARADDR[1:0];

  // Out-of-range beats are flagged from the full word index; the RAM only sees the low bits.
  assign beat_err = err_q | (|addr_q[WAW-1:IDXW]);
  assign ram_idx  = addr_d[IDXW-1:0];

  always_comb begin
    state_d = state_q;
    rid_d   = rid_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fixed_d = fixed_q;
    ram_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (axi.ARVALID) begin
          rid_d   = axi.ARID;
          addr_d  = axi.ARADDR[C_AXI_ADDR_WIDTH-1:2];
          cnt_d   = axi.ARLEN;
          err_d   = (axi.ARSIZE != 3'b010) | axi.ARBURST[1];
          fixed_d = (axi.ARBURST == 2'b00);
          state_d = FETCH;
        end
      end
      FETCH: begin
        ram_re  = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (axi.RREADY) begin
          if (cnt_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            // Read the next word in the firing cycle so the following beat has no bubble.
            cnt_d  = cnt_q - 8'd1;
            addr_d = fixed_q ? addr_q : addr_q + 1'b1;
            ram_re = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXI_CLK) begin
    if (AXI_RST) begin
      state_q <= IDLE;
      rid_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fixed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rid_q   <= rid_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fixed_q <= fixed_d;
    end
  end

  // Read only when enabled so a preload to the word on display cannot disturb a stalled beat.
  always_ff @(posedge AXI_CLK) begin
    if (LOAD_EN) mem[LOAD_ADDR] <= LOAD_DATA;
    if (ram_re)  ram_q <= mem[ram_idx];
  end

  assign axi.ARREADY = (state_q == IDLE) && !AXI_RST;
  assign axi.RVALID  = (state_q == SEND);
  assign axi.RLAST   = (state_q == SEND) && (cnt_q == 8'd0);
  assign axi.RRESP   = ((state_q == SEND) && beat_err) ? 2'b10 : 2'b00;
  assign axi.RDATA   = ((state_q == SEND) && !beat_err) ? ram_q : '0;
  assign axi.RID     = rid_q;
endmodule
